// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and helpers for the serial pattern detector
package seq_det_pkg;

  localparam bit MODE_MOORE = 1'b1;
  localparam bit MODE_MEALY = 1'b0;
  localparam bit OVL_ON     = 1'b1;
  localparam bit OVL_OFF    = 1'b0;

  // Bits needed to hold the values 0..n (used for the history fill count)
  function automatic int fill_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < (n + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Increment on request, holding once the all-ones value is reached
  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared synchronously
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial bit-pattern detector with match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 SEQ_LEN = 3,
  parameter logic [SEQ_LEN-1:0] PATTERN = 3'b101,
  parameter bit                 OVERLAP = OVL_ON,
  parameter bit                 MOORE   = MODE_MOORE,
  parameter int                 CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in,
  input  logic               en,
  input  logic               pat_we,
  input  logic [SEQ_LEN-1:0] pat_in,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int            FW       = fill_width(SEQ_LEN);
  localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_LEN);
  localparam logic [FW-1:0] FILL_MIN = FW'(SEQ_LEN - 1);

  logic [SEQ_LEN-1:0] hist_d, hist_q;
  logic [FW-1:0]      fill_d, fill_q;
  logic [SEQ_LEN-1:0] pat_d,  pat_q;
  logic               out_d,  out_q;

  logic [SEQ_LEN-1:0] shifted;
  logic               match_cond;
  logic               accept;
  logic               hit;

  // Candidate window including the bit on the input, and whether it completes the pattern
  always_comb begin
    shifted    = {hist_q[SEQ_LEN-2:0], in};
    match_cond = (shifted == pat_q) && (fill_q >= FILL_MIN);
    // A pattern load on the same edge drops the incoming bit
    accept     = en && !pat_we;
    hit        = accept && match_cond;
  end

  // Next-state for history, fill level, pattern and the Moore output
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    out_d  = out_q;
    if (pat_we) begin
      pat_d  = pat_in;
      fill_d = '0;
      out_d  = 1'b0;
    end else if (en) begin
      hist_d = shifted;
      out_d  = match_cond;
      if (match_cond) begin
        // Non-overlapping mode forces a full fresh window before the next match
        fill_d = OVERLAP ? FILL_MAX : '0;
      end else if (fill_q < FILL_MAX) begin
        fill_d = fill_q + FW'(1);
      end
    end
  end

  // Detector state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= out_d;
    end
  end

  assign out = MOORE ? out_q : hit;

  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit),
    .cnt   (match_cnt)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  import seq_det_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       d_in, d_en, d_we;
  logic [2:0] d_pat;
  logic       s_in, s_en, s_we;
  logic [1:0] s_pat;

  logic       a_out, b_out, m_out, s_out;
  logic [7:0] a_cnt, b_cnt, m_cnt;
  logic [1:0] s_cnt;

  int compared;
  int mismatched;

  // Defaults: 101, overlapping, Moore
  seq_detector_param u_a (
    .clk(clk), .rst_n(rst_n), .in(d_in), .en(d_en), .pat_we(d_we), .pat_in(d_pat),
    .out(a_out), .match_cnt(a_cnt)
  );

  // Non-overlapping Moore
  seq_detector_param #(.OVERLAP(OVL_OFF)) u_b (
    .clk(clk), .rst_n(rst_n), .in(d_in), .en(d_en), .pat_we(d_we), .pat_in(d_pat),
    .out(b_out), .match_cnt(b_cnt)
  );

  // Overlapping Mealy
  seq_detector_param #(.MOORE(MODE_MEALY)) u_m (
    .clk(clk), .rst_n(rst_n), .in(d_in), .en(d_en), .pat_we(d_we), .pat_in(d_pat),
    .out(m_out), .match_cnt(m_cnt)
  );

  // Two-bit pattern 11 with a 2-bit counter for saturation
  seq_detector_param #(.SEQ_LEN(2), .PATTERN(2'b11), .CNT_W(2)) u_s (
    .clk(clk), .rst_n(rst_n), .in(s_in), .en(s_en), .pat_we(s_we), .pat_in(s_pat),
    .out(s_out), .match_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic b, input logic e, input logic w, input logic [2:0] p);
    @(negedge clk);
    d_in  = b;
    d_en  = e;
    d_we  = w;
    d_pat = p;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic s2_bits [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic s2_a    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic s2_b    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic s5_bits [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic s5_exp  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic s6_out  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [1:0] s6_cnt [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    d_in = 1'b0; d_en = 1'b0; d_we = 1'b0; d_pat = 3'b000;
    s_in = 1'b0; s_en = 1'b0; s_we = 1'b0; s_pat = 2'b11;

    // Reset state
    tick();
    tick();
    chk("rst_a_out", a_out, 0);
    chk("rst_b_out", b_out, 0);
    chk("rst_m_out", m_out, 0);
    chk("rst_s_out", s_out, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_b_cnt", b_cnt, 0);
    chk("rst_m_cnt", m_cnt, 0);
    chk("rst_s_cnt", s_cnt, 0);
    rst_n = 1'b1;

    // Stream 1,0,1,0,1: overlap vs non-overlap, Moore vs Mealy
    for (int i = 0; i < 5; i++) begin
      drive(s2_bits[i], 1'b1, 1'b0, 3'b000);
      chk("s2_mealy_out", m_out, s2_a[i]);
      tick();
      chk("s2_moore_ovl_out", a_out, s2_a[i]);
      chk("s2_moore_novl_out", b_out, s2_b[i]);
    end
    chk("s2_a_cnt", a_cnt, 2);
    chk("s2_b_cnt", b_cnt, 1);
    chk("s2_m_cnt", m_cnt, 2);

    // Reset mid-pattern after 1,0
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    tick();
    chk("s3_a_nomatch1", a_out, 0);
    drive(1'b0, 1'b1, 1'b0, 3'b000);
    tick();
    chk("s3_a_nomatch0", a_out, 0);
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    rst_n = 1'b0;
    tick();
    chk("s3_rst_a_out", a_out, 0);
    chk("s3_rst_a_cnt", a_cnt, 0);
    chk("s3_rst_b_cnt", b_cnt, 0);
    chk("s3_rst_m_cnt", m_cnt, 0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    chk("s3_single1_mealy", m_out, 0);
    tick();
    chk("s3_single1_moore", a_out, 0);
    chk("s3_single1_cnt", a_cnt, 0);
    drive(1'b0, 1'b1, 1'b0, 3'b000);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    chk("s3_full_mealy", m_out, 1);
    tick();
    chk("s3_full_a_out", a_out, 1);
    chk("s3_full_b_out", b_out, 1);
    chk("s3_full_a_cnt", a_cnt, 1);
    chk("s3_full_m_cnt", m_cnt, 1);

    // Mealy with en low for two cycles before the final 1
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 3'b000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    chk("s4_gap1_mealy", m_out, 0);
    tick();
    chk("s4_gap1_moore", a_out, 0);
    drive(1'b1, 1'b0, 1'b0, 3'b000);
    chk("s4_gap2_mealy", m_out, 0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    chk("s4_final_mealy", m_out, 1);
    tick();
    chk("s4_final_moore", a_out, 1);
    chk("s4_m_cnt", m_cnt, 1);
    chk("s4_a_cnt", a_cnt, 1);
    drive(1'b0, 1'b0, 1'b0, 3'b000);
    tick();
    chk("s4_moore_hold", a_out, 1);

    // Pattern reload to 110 with a bit presented on the load edge
    drive(1'b1, 1'b1, 1'b0, 3'b000);
    tick();
    chk("s5_pre1_a_out", a_out, 0);
    drive(1'b0, 1'b1, 1'b0, 3'b000);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'b110);
    chk("s5_load_mealy", m_out, 0);
    tick();
    chk("s5_load_moore", a_out, 0);
    chk("s5_load_a_cnt", a_cnt, 1);
    chk("s5_load_b_cnt", b_cnt, 1);
    for (int i = 0; i < 5; i++) begin
      drive(s5_bits[i], 1'b1, 1'b0, 3'b000);
      chk("s5_mealy_out", m_out, s5_exp[i]);
      tick();
      chk("s5_moore_out", a_out, s5_exp[i]);
    end
    chk("s5_a_cnt", a_cnt, 2);
    chk("s5_b_cnt", b_cnt, 2);
    chk("s5_m_cnt", m_cnt, 2);
    drive(1'b0, 1'b0, 1'b0, 3'b000);

    // Saturation: pattern 11 on six 1s with a 2-bit counter
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s_in = 1'b1;
      s_en = 1'b1;
      tick();
      chk("s6_sat_out", s_out, s6_out[i]);
      chk("s6_sat_cnt", s_cnt, s6_cnt[i]);
    end
    @(negedge clk);
    s_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
